alu_wide_op_sequencer: RTL and testbench
========================================

Name: alu_wide_op_sequencer

Overview:
- Multi-cycle controller that runs WORDS×32-bit arithmetic/logic operations on the existing 32-bit Exe-stage ALU, one word per cycle, least-significant word first.
- Chains the ALU carry between words and merges per-word flags into final N/Z/C/V.
- Sits beside the ALU in the Exe stage. Owns the ALU input bus while busy; uses a valid/ready request/response handshake toward the issuing logic.

Parameters:
- WORDS, 2, number of 32-bit words per operand (legal range 2..8).
- W, 32, ALU word width (fixed to match the ALU).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  4  ALU opcode: MOV 0001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MVN 1001.
- req_cin  in  1  carry-in used by ADC/SBC on word 0.
- req_a  in  W*WORDS  operand A.
- req_b  in  W*WORDS  operand B.
- alu_srcA  out  W  word of A driven to the ALU.
- alu_srcB  out  W  word of B driven to the ALU.
- alu_op  out  4  opcode driven to the ALU.
- alu_cin  out  1  carry-in driven to the ALU.
- alu_result  in  W  ALU result.
- alu_c, alu_v, alu_z, alu_n  in  1 each  ALU flags.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_result  out  W*WORDS  wide result.
- resp_n, resp_z, resp_c, resp_v  out  1 each  wide flags.

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_result=0, all resp flags 0, word index 0, alu_* outputs 0. Reset mid-RUN or mid-DONE discards the operation and returns to IDLE next cycle.
- FSM IDLE:
  - req_ready=1.
  - On req_valid: latch op, cin, A, B; clear result and flag accumulators; index=0; go to RUN.
- FSM RUN:
  - req_ready=0.
  - alu_srcA/alu_srcB = word[index] of latched A/B, driven combinationally from registers.
  - Each edge: result word[index] <= alu_result; carry <= alu_c; zacc <= zacc & alu_z (zacc=1 at start).
  - At index==WORDS-1: also capture N, C, V from the ALU; go to DONE. Otherwise index+1.
- Opcode mapping:
  - word 0 uses req_op.
  - Words ≥1: ADD/ADC→ADC (0011); SUB/SBC→SBC (0101); all other ops unchanged.
- Carry-in:
  - word 0: req_cin for ADC/SBC, else 0.
  - Words ≥1: registered alu_c of the previous word. C follows ALU convention: C=1 means no borrow on subtract.
- Flags:
  - resp_n = bit W*WORDS-1 of the result.
  - resp_z = 1 iff all words are zero.
  - resp_c and resp_v come from the last word; both are 0 for logic/move ops.
- Illegal opcode: forwarded unchanged; ALU returns 0, so the result is 0 with Z=1, C=V=N=0. Latency is unchanged.
- Outside RUN: alu_op=0000, alu_srcA/alu_srcB/alu_cin=0.
- FSM DONE:
  - resp_valid=1; resp_result and resp flags stay stable until resp_ready.
  - resp_ready → IDLE and resp_valid=0 next cycle.
- Latency: acceptance edge T; resp_valid rises after edge T+WORDS. Throughput is one operation per WORDS+2 cycles.

Optional Feature:
- Macro: ALU_WIDE_SEQ_BACK2BACK_EN.
- With the macro: in DONE, req_ready=resp_ready. If resp_ready and req_valid are both high, the new request is latched and the FSM goes directly to RUN, giving one operation per WORDS+1 cycles.
- Without the macro: req_ready=0 in DONE, and a request is only accepted from IDLE.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams (OP_MOV..OP_MVN);
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - word-width constant 32.
- One natural combinational sub-module, alu_seq_op_map: inputs (req_op, first_word, req_cin, carry_reg); outputs (alu_op, alu_cin).
- The FSM, index counter and accumulators remain in the top-level module.

Test Plan:
- ADD A=0x00000000_FFFFFFFF, B=1 → alu_op 0010 then 0011, second alu_cin=1; result 0x00000001_00000000, N=0 Z=0 C=0 V=0; resp_valid after edge T+2.
- SUB A=0x00000001_00000000, B=1 → ops 0100 then 0101, second alu_cin=0; result 0x00000000_FFFFFFFF, C=1 V=0 N=0 Z=0.
- ADD A=0x7FFFFFFF_FFFFFFFF, B=1 → 0x80000000_00000000, N=1 V=1 C=0 Z=0.
- EOR A=B=0x12345678_9ABCDEF0 → result 0, Z=1, C=V=0. AND A=0xFFFF0000_00000000, B=all-ones → Z=0, N=1 (low word zero does not set Z).
- Hold resp_ready=0 for 5 cycles → resp_valid and result stable, req_ready=0. Assert rst during RUN → next cycle IDLE, resp_valid=0, req_ready=1.
- Macro on: req_valid and resp_ready high in DONE → new op enters RUN with no IDLE cycle. Macro off: the same stimulus is not accepted until IDLE.

Source files
------------

// File: rtl/alu_wide_op_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and ALU word width for the wide-op sequencer.
package alu_seq_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Ops whose word-0 carry-in comes from the request rather than being forced to 0.
  function automatic logic uses_req_cin(input logic [3:0] op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/alu_wide_op_sequencer_if.sv
// Request/response and ALU-bus signals of the wide-op sequencer; slave = sequencer side.
interface alu_wide_op_sequencer_if import alu_seq_pkg::*; #(
  parameter int WORDS = 2
);
  localparam int WW = ALU_W * WORDS;

  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic              req_cin;
  logic [WW-1:0]     req_a;
  logic [WW-1:0]     req_b;

  logic [ALU_W-1:0]  alu_srcA;
  logic [ALU_W-1:0]  alu_srcB;
  logic [3:0]        alu_op;
  logic              alu_cin;
  logic [ALU_W-1:0]  alu_result;
  logic              alu_c;
  logic              alu_v;
  logic              alu_z;
  logic              alu_n;

  logic              resp_valid;
  logic              resp_ready;
  logic [WW-1:0]     resp_result;
  logic              resp_n;
  logic              resp_z;
  logic              resp_c;
  logic              resp_v;

  modport slave (
    input  req_valid, req_op, req_cin, req_a, req_b,
    output req_ready,
    output alu_srcA, alu_srcB, alu_op, alu_cin,
    input  alu_result, alu_c, alu_v, alu_z, alu_n,
    output resp_valid, resp_result, resp_n, resp_z, resp_c, resp_v,
    input  resp_ready
  );

  modport master (
    output req_valid, req_op, req_cin, req_a, req_b,
    input  req_ready,
    input  alu_srcA, alu_srcB, alu_op, alu_cin,
    output alu_result, alu_c, alu_v, alu_z, alu_n,
    input  resp_valid, resp_result, resp_n, resp_z, resp_c, resp_v,
    output resp_ready
  );

endinterface

// File: rtl/alu_wide_op_sequencer_op_map.sv
// Per-word opcode and carry-in selection: upper words turn ADD/SUB into their carry-chained forms.
module alu_seq_op_map import alu_seq_pkg::*; (
  input  logic [3:0] req_op,
  input  logic       first_word,
  input  logic       req_cin,
  input  logic       carry_reg,
  output logic [3:0] alu_op,
  output logic       alu_cin
);

  always_comb begin
    alu_op  = req_op;
    alu_cin = 1'b0;
    if (first_word) begin
      if (uses_req_cin(req_op)) alu_cin = req_cin;
    end else begin
      // Carry from the previous word also serves as the not-borrow for SBC.
      alu_cin = carry_reg;
      if (req_op == OP_ADD || req_op == OP_ADC) alu_op = OP_ADC;
      else if (req_op == OP_SUB || req_op == OP_SBC) alu_op = OP_SBC;
    end
  end

endmodule

// File: rtl/alu_wide_op_sequencer.sv
// Runs WORDS x 32-bit ops on the shared Exe ALU, LS word first, one word per cycle.
// Optional ALU_WIDE_SEQ_BACK2BACK_EN lets DONE accept the next request on resp handoff.
module alu_wide_op_sequencer import alu_seq_pkg::*; #(
  parameter int WORDS = 2,
  parameter int W     = ALU_W
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_wide_op_sequencer_if.slave bus
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  seq_state_t          state;
  logic [IW-1:0]       idx;
  logic [3:0]          op_q;
  logic                cin_q;
  logic                carry_q;
  logic [W*WORDS-1:0]  a_q;
  logic [W*WORDS-1:0]  b_q;
  logic [W*WORDS-1:0]  res_q;
  logic                zacc;
  logic                n_q;
  logic                z_q;
  logic                c_q;
  logic                v_q;

  logic                running;
  logic                accept;
  logic [3:0]          map_op;
  logic                map_cin;

  assign running = (state == RUN);

`ifdef ALU_WIDE_SEQ_BACK2BACK_EN
  assign bus.req_ready = (state == IDLE) || ((state == DONE) && bus.resp_ready);
`else
  assign bus.req_ready = (state == IDLE);
`endif

  assign accept = bus.req_valid && bus.req_ready;

  alu_seq_op_map u_op_map (
    .req_op     (op_q),
    .first_word (idx == '0),
    .req_cin    (cin_q),
    .carry_reg  (carry_q),
    .alu_op     (map_op),
    .alu_cin    (map_cin)
  );

  // The ALU bus is parked at zero whenever the sequencer does not own it.
  assign bus.alu_op   = running ? map_op : OP_NOP;
  assign bus.alu_cin  = running && map_cin;
  assign bus.alu_srcA = running ? a_q[W*int'(idx) +: W] : '0;
  assign bus.alu_srcB = running ? b_q[W*int'(idx) +: W] : '0;

  assign bus.resp_valid  = (state == DONE);
  assign bus.resp_result = res_q;
  assign bus.resp_n      = n_q;
  assign bus.resp_z      = z_q;
  assign bus.resp_c      = c_q;
  assign bus.resp_v      = v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      op_q    <= OP_NOP;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zacc    <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else if (accept) begin
      state   <= RUN;
      idx     <= '0;
      op_q    <= bus.req_op;
      cin_q   <= bus.req_cin;
      carry_q <= 1'b0;
      a_q     <= bus.req_a;
      b_q     <= bus.req_b;
      res_q   <= '0;
      zacc    <= 1'b1;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          res_q[W*int'(idx) +: W] <= bus.alu_result;
          carry_q                 <= bus.alu_c;
          zacc                    <= zacc & bus.alu_z;
          if (idx == LAST) begin
            // Sign, carry and overflow of the wide op are those of its top word.
            n_q   <= bus.alu_n;
            c_q   <= bus.alu_c;
            v_q   <= bus.alu_v;
            z_q   <= zacc & bus.alu_z;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.resp_ready) state <= IDLE;
        end
        IDLE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_op_sequencer.sv
// Bench for alu_wide_op_sequencer: behavioural ALU, wide-arithmetic model and per-cycle compare.
`timescale 1ns/1ps
module tb_alu_wide_op_sequencer;
  import alu_seq_pkg::*;

  localparam int WORDS = 2;
  localparam int W     = 32;
  localparam int WW    = W * WORDS;

  typedef logic [WW-1:0] wide_t;
  typedef struct packed {
    wide_t r;
    logic  n;
    logic  z;
    logic  c;
    logic  v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_wide_op_sequencer_if #(.WORDS(WORDS)) bus();

  alu_wide_op_sequencer #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic chk(input string name, input wide_t act, input wide_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, WW'(act), WW'(exp));
  endtask

  // Behavioural 32-bit ALU standing in for the Exe-stage ALU.
  logic [W:0]   alu_s;
  logic [W-1:0] alu_bb;
  logic [W-1:0] alu_r;
  logic         alu_ci;
  logic         alu_arith;
  always_comb begin
    alu_s     = '0;
    alu_bb    = bus.alu_srcB;
    alu_r     = '0;
    alu_ci    = 1'b0;
    alu_arith = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin alu_arith = 1'b1; end
      OP_ADC: begin alu_arith = 1'b1; alu_ci = bus.alu_cin; end
      OP_SUB: begin alu_arith = 1'b1; alu_bb = ~bus.alu_srcB; alu_ci = 1'b1; end
      OP_SBC: begin alu_arith = 1'b1; alu_bb = ~bus.alu_srcB; alu_ci = bus.alu_cin; end
      OP_MOV: alu_r = bus.alu_srcB;
      OP_MVN: alu_r = ~bus.alu_srcB;
      OP_AND: alu_r = bus.alu_srcA & bus.alu_srcB;
      OP_ORR: alu_r = bus.alu_srcA | bus.alu_srcB;
      OP_EOR: alu_r = bus.alu_srcA ^ bus.alu_srcB;
      default: alu_r = '0;
    endcase
    if (alu_arith) begin
      alu_s = {1'b0, bus.alu_srcA} + {1'b0, alu_bb} + (W+1)'(alu_ci);
      alu_r = alu_s[W-1:0];
    end
    bus.alu_result = alu_r;
    bus.alu_c      = alu_arith & alu_s[W];
    bus.alu_v      = alu_arith & (bus.alu_srcA[W-1] == alu_bb[W-1]) & (alu_r[W-1] != bus.alu_srcA[W-1]);
    bus.alu_z      = (alu_r == '0);
    bus.alu_n      = alu_r[W-1];
  end

  function automatic logic is_arith(input logic [3:0] op);
    return op == OP_ADD || op == OP_ADC || op == OP_SUB || op == OP_SBC;
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return op == OP_SUB || op == OP_SBC;
  endfunction

  function automatic logic carry0(input logic [3:0] op, input logic cin);
    if (op == OP_ADD) return 1'b0;
    if (op == OP_SUB) return 1'b1;
    return cin;
  endfunction

  // Whole-operand result of the wide operation, computed at full width in one step.
  function automatic exp_t model(input logic [3:0] op, input logic cin, input wide_t a, input wide_t b);
    exp_t        e;
    logic [WW:0] s;
    wide_t       bb;
    e  = '0;
    bb = is_sub(op) ? ~b : b;
    if (is_arith(op)) begin
      s   = {1'b0, a} + {1'b0, bb} + (WW+1)'(carry0(op, cin));
      e.r = s[WW-1:0];
      e.c = s[WW];
      e.v = (a[WW-1] == bb[WW-1]) && (e.r[WW-1] != a[WW-1]);
    end else begin
      case (op)
        OP_MOV: e.r = b;
        OP_MVN: e.r = ~b;
        OP_AND: e.r = a & b;
        OP_ORR: e.r = a | b;
        OP_EOR: e.r = a ^ b;
        default: e.r = '0;
      endcase
    end
    e.n = e.r[WW-1];
    e.z = (e.r == '0);
    return e;
  endfunction

  function automatic logic [3:0] word_op(input logic [3:0] op, input int k);
    if (k == 0) return op;
    if (op == OP_ADD || op == OP_ADC) return OP_ADC;
    if (op == OP_SUB || op == OP_SBC) return OP_SBC;
    return op;
  endfunction

  // Carry into word k = carry out of the low k words of the wide sum.
  function automatic logic word_cin(input logic [3:0] op, input logic cin, input wide_t a, input wide_t b, input int k);
    logic [WW:0] mask;
    logic [WW:0] s;
    wide_t       bb;
    if (k == 0) return (op == OP_ADC || op == OP_SBC) ? cin : 1'b0;
    if (!is_arith(op)) return 1'b0;
    bb   = is_sub(op) ? ~b : b;
    mask = ((WW+1)'(1) << (k * W)) - (WW+1)'(1);
    s    = ({1'b0, a} & mask) + ({1'b0, bb} & mask) + (WW+1)'(carry0(op, cin));
    return s[k * W];
  endfunction

  // Transaction-level tracker: 0 idle, 1 running word wc, 2 holding the response.
  int          ph = 0;
  int          wc = 0;
  logic [3:0]  t_op;
  logic        t_cin;
  wide_t       t_a;
  wide_t       t_b;
  exp_t        m_e;
  logic        exp_rdy;

  always @(negedge clk) begin
    if (chk_en) begin
      if (ph == 2)
`ifdef ALU_WIDE_SEQ_BACK2BACK_EN
        exp_rdy = bus.resp_ready;
`else
        exp_rdy = 1'b0;
`endif
      else
        exp_rdy = (ph == 0);
      chk1("req_ready", bus.req_ready, exp_rdy);
      chk1("resp_valid", bus.resp_valid, ph == 2);
      if (ph == 1) begin
        chk("alu_op", WW'(bus.alu_op), WW'(word_op(t_op, wc)));
        chk1("alu_cin", bus.alu_cin, word_cin(t_op, t_cin, t_a, t_b, wc));
        chk("alu_srcA", WW'(bus.alu_srcA), WW'(t_a[wc*W +: W]));
        chk("alu_srcB", WW'(bus.alu_srcB), WW'(t_b[wc*W +: W]));
      end else begin
        chk("alu_idle", WW'({bus.alu_op, bus.alu_cin, bus.alu_srcA, bus.alu_srcB}), '0);
      end
      if (ph == 2) begin
        m_e = model(t_op, t_cin, t_a, t_b);
        chk("resp_result", bus.resp_result, m_e.r);
        chk("resp_nzcv", WW'({bus.resp_n, bus.resp_z, bus.resp_c, bus.resp_v}),
            WW'({m_e.n, m_e.z, m_e.c, m_e.v}));
      end
      if (rst) begin
        ph = 0;
      end else if (ph == 0) begin
        if (bus.req_valid) begin
          ph = 1; wc = 0;
          t_op = bus.req_op; t_cin = bus.req_cin; t_a = bus.req_a; t_b = bus.req_b;
        end
      end else if (ph == 1) begin
        if (wc == WORDS - 1) ph = 2;
        else wc++;
      end else if (bus.resp_ready) begin
        ph = 0;
`ifdef ALU_WIDE_SEQ_BACK2BACK_EN
        if (bus.req_valid) begin
          ph = 1; wc = 0;
          t_op = bus.req_op; t_cin = bus.req_cin; t_a = bus.req_a; t_b = bus.req_b;
        end
`endif
      end
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 20);
  endtask

  task automatic release_resp();
    @(posedge clk); #1 bus.resp_ready = 1'b1;
    @(posedge clk); #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk1("resp_valid_drop", bus.resp_valid, 1'b0);
  endtask

  task automatic drive_req(input logic [3:0] op, input logic cin, input wide_t a, input wide_t b);
    bus.req_op = op; bus.req_cin = cin; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic cin, input wide_t a, input wide_t b,
                        input wide_t er, input logic [3:0] enzcv, input int hold);
    exp_t m;
    int   lat;
    m = model(op, cin, a, b);
    chk("model_result", m.r, er);
    chk("model_nzcv", WW'({m.n, m.z, m.c, m.v}), WW'(enzcv));
    @(posedge clk); #1 drive_req(op, cin, a, b);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    wait_done(lat);
    chk("latency", WW'(lat), WW'(WORDS + 1));
    chk("result", bus.resp_result, er);
    chk("nzcv", WW'({bus.resp_n, bus.resp_z, bus.resp_c, bus.resp_v}), WW'(enzcv));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk1("hold_valid", bus.resp_valid, 1'b1);
      chk("hold_result", bus.resp_result, er);
      chk1("hold_req_ready", bus.req_ready, 1'b0);
    end
    release_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_cin = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_req_ready", bus.req_ready, 1'b1);
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_result", bus.resp_result, '0);
    chk("rst_flags", WW'({bus.resp_n, bus.resp_z, bus.resp_c, bus.resp_v}), '0);
    chk("rst_alu", WW'({bus.alu_op, bus.alu_cin, bus.alu_srcA, bus.alu_srcB}), '0);
    @(posedge clk); #1 rst = 1'b0; chk_en = 1'b1;

    run_op(OP_ADD, 1'b0, 64'h00000000_FFFFFFFF, 64'h1, 64'h00000001_00000000, 4'b0000, 0);
    run_op(OP_SUB, 1'b0, 64'h00000001_00000000, 64'h1, 64'h00000000_FFFFFFFF, 4'b0010, 0);
    run_op(OP_ADD, 1'b0, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 64'h80000000_00000000, 4'b1001, 0);
    run_op(OP_EOR, 1'b0, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 64'h0, 4'b0100, 0);
    run_op(OP_AND, 1'b0, 64'hFFFF0000_00000000, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFF0000_00000000, 4'b1000, 5);
    run_op(OP_ADC, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 64'h0, 4'b0110, 0);
    run_op(OP_SBC, 1'b0, 64'h0, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 4'b1000, 0);
    run_op(OP_MVN, 1'b0, 64'h5, 64'h0F0F0F0F_00000000, 64'hF0F0F0F0_FFFFFFFF, 4'b1000, 0);
    run_op(OP_MOV, 1'b1, 64'hDEADBEEF_00000001, 64'h0, 64'h0, 4'b0100, 0);
    run_op(4'hC, 1'b1, 64'hDEADBEEF_CAFEF00D, 64'h12345678_9ABCDEF0, 64'h0, 4'b0100, 0);
    run_op(OP_ORR, 1'b0, 64'h00000000_00000001, 64'h80000000_00000000, 64'h80000000_00000001, 4'b1000, 0);

    // Reset while the first word is on the ALU.
    @(posedge clk); #1 drive_req(OP_ADD, 1'b0, 64'h1, 64'h2);
    @(posedge clk); #1 bus.req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("midrst_req_ready", bus.req_ready, 1'b1);
    chk1("midrst_resp_valid", bus.resp_valid, 1'b0);
    chk("midrst_result", bus.resp_result, '0);
    chk("midrst_alu_op", WW'(bus.alu_op), '0);
    run_op(OP_ADD, 1'b0, 64'h1, 64'h2, 64'h3, 4'b0000, 0);

    // New request offered in the same cycle the response is taken.
    @(posedge clk); #1 drive_req(OP_ADD, 1'b0, 64'h00000000_FFFFFFFF, 64'h1);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    wait_done(lat);
    chk("b2b_first_result", bus.resp_result, 64'h00000001_00000000);
    @(posedge clk); #1 drive_req(OP_SUB, 1'b0, 64'h00000001_00000000, 64'h1); bus.resp_ready = 1'b1;
    @(posedge clk); #1 bus.resp_ready = 1'b0;
`ifdef ALU_WIDE_SEQ_BACK2BACK_EN
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk1("b2b_req_ready", bus.req_ready, 1'b0);
    chk("b2b_alu_op", WW'(bus.alu_op), WW'(OP_SUB));
`else
    @(negedge clk);
    chk1("nob2b_req_ready", bus.req_ready, 1'b1);
    chk("nob2b_alu_op", WW'(bus.alu_op), '0);
    @(posedge clk); #1 bus.req_valid = 1'b0;
`endif
    chk1("b2b_resp_valid", bus.resp_valid, 1'b0);
    wait_done(lat);
    chk1("b2b_second_valid", bus.resp_valid, 1'b1);
    chk("b2b_second_result", bus.resp_result, 64'h00000000_FFFFFFFF);
    release_resp();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
